// File: rtl/gf2m_reduce_serial.sv
// Serial GF(2^m) reduction: clears one product degree per clock, top-down,
// then presents the m-bit remainder under a valid/ready handshake.
module gf2m_reduce_serial #(
  parameter int          M    = 8,
  parameter logic [M:0]  POLY = 9'h11B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-2:0] prod_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   res_out,
  output logic           busy
);
  localparam int CW = (M > 2) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2*M-2:0] r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-2:0] poly_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    poly_ext      = '0;
    poly_ext[M:0] = POLY;
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r_d     = prod_in;
          cnt_d   = CW'(M - 2);
          state_d = RUN;
        end
      end
      RUN: begin
        // Degree M+cnt is the current leading term to cancel.
        if (r_q[M + int'(cnt_q)])
          r_d = r_q ^ (poly_ext << cnt_q);
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_out = r_q[M-1:0];
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/gf2m_reduce_serial.md
# gf2m_reduce_serial

Sequential modular reduction stage for GF(2^m) arithmetic. Sits directly downstream of the combinational single-cycle Karatsuba multiplier. It accepts that multiplier's unreduced (2m-1)-bit polynomial product and reduces it modulo the field polynomial, one degree per clock. It returns the m-bit field element under a valid/ready handshake. Used by the ALU1 datapath in the Niederreiter cryptoprocessor ASIP.

## Interface
- m, 8, field degree; product width 2m-1, result width m; m >= 2
- POLY, 9'h11B, irreducible field polynomial, width m+1; bit m must be 1
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  prod_in is valid
- in_ready  output  1  block can accept a product
- prod_in  input  2m-1  unreduced product from the multiplier, bit i = coefficient of x^i
- out_valid  output  1  res_out is valid
- out_ready  input  1  consumer takes res_out
- res_out  output  m  reduced product, prod_in mod POLY
- busy  output  1  high while not IDLE

## Operation
- Registers: r (2m-1 bits, working remainder), cnt (ceil(log2(m)) bits), state.
- State IDLE: in_ready=1.
  - On in_valid: load r<=prod_in and cnt<=m-2, then go to RUN.
- State RUN: in_ready=0.
  - Each cycle: if r[m+cnt]==1, r <= r ^ (POLY << cnt); otherwise r is unchanged.
  - If cnt==0, go to DONE; otherwise cnt<=cnt-1.
  - Degrees are cleared top-down, from 2m-2 to m.
- State DONE: out_valid=1 and res_out=r[m-1:0].
  - Hold both stable until out_ready. On out_ready, go to IDLE.
  - in_ready=0 in DONE, so there is no back-to-back accept.
- res_out is driven from r[m-1:0] at all times. It is meaningful only when out_valid=1.
- Arithmetic is over GF(2) only: XOR, no carries.
  - Upper bits r[2m-2:m] are all zero when DONE is reached.
  - POLY bit m is never checked by hardware. Supplying a non-irreducible POLY gives the polynomial remainder anyway.
- in_valid is ignored in RUN and DONE. prod_in is sampled only on the accept edge. The upstream must hold it until in_ready.
- out_ready while out_valid=0 has no effect.
- busy = (state != IDLE).

## Timing
- Reset (rst=1 at an edge) forces IDLE, r=0, cnt=0. This gives in_ready=1, out_valid=0, busy=0, res_out=0.
  - Reset overrides any state, including mid-RUN or DONE. An in-flight result is discarded with no output.
  - rst has priority over simultaneous in_valid/out_ready.
- Accept happens at edge T (in_valid & in_ready).
  - RUN occupies the m-1 cycles after edge T.
  - out_valid rises after edge T+m-1. For m=8 that is 7 cycles of latency.
- Latency is fixed and independent of data, including prod_in < 2^m.
- A result is consumed at edge U (out_valid & out_ready). in_ready=1 from after edge U.
  - The next accept happens at edge U+1 at the earliest.
  - Minimum initiation interval is m+1 cycles.
- With out_ready held low, DONE persists indefinitely with no change in outputs.

## Test plan
- Reset check: rst high for 2 cycles.
  - Required: in_ready=1, out_valid=0, busy=0, res_out=0.
- FIPS-197 vector, m=8, POLY=0x11B: prod_in=0x2B79 (carry-less 0x57·0x83), out_ready=1.
  - Required: res_out=0xC1, out_valid exactly 7 cycles after accept.
- Single top term and all-ones:
  - prod_in=0x4000 → 0x9A.
  - prod_in=0x7FFF → 0x1A.
  - prod_in=0x00A5 → 0xA5, still after 7 cycles.
- Backpressure: accept 0x2B79 with out_ready=0 for 10 cycles, and pulse in_valid with 0x4000 during that time.
  - Required: 0xC1 holds stable and the second input is not accepted.
  - After out_ready, in_ready returns; re-present 0x4000 → 0x9A.
- Mid-operation reset: accept 0x7FFF, assert rst on the 3rd RUN cycle.
  - Required: IDLE next cycle, no out_valid pulse.
  - A subsequent 0x2B79 → 0xC1.
- Random regression: 1000 random prod_in with random out_ready stalls.
  - Required: each res_out equals the software GF(2) polynomial remainder mod POLY, in order, with no drops or duplicates.
